std_io_in_filt: RTL and testbench

//  Receive side of a bidirectional pad: samples inout pad, synchronises to clk, digitally
//  de-glitches, reports filtered level plus one-cycle rise/fall strobes.

---
 rtl/std_io_in_filt_pkg.sv | 18 +
 rtl/std_io_in_filt_sync.sv | 35 +++
 rtl/std_io_in_filt.sv | 154 +++++++++++++++
 tb/tb_std_io_in_filt.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_io_in_filt_pkg.sv
// ============================================================================
// std_io_in_filt_pkg : shared constants and pad-sampling helper
// Rev 1.0
// ============================================================================
`default_nettype none

package std_io_in_filt_pkg;

    localparam int STD_SYNC_MIN_STAGES = 2;

    // Anything other than a solid 1 on the pad (0, Z, X) is read as 0.
    function automatic logic pad_high(input logic p);
        return (p === 1'b1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/std_io_in_filt_sync.sv
// ============================================================================
// std_sync_chain : multi-flop synchroniser with async active-low reset
// Rev 1.0
// ============================================================================
`default_nettype none

module std_sync_chain
    import std_io_in_filt_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clrn,
    input  logic d_i,
    output logic q_o
);

    localparam int N = (STAGES < STD_SYNC_MIN_STAGES) ? STD_SYNC_MIN_STAGES : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

`default_nettype wire

// File: rtl/std_io_in_filt.sv
// ============================================================================
// std_io_in_filt : pad receive path - synchronise, de-glitch, edge strobes,
//                  and contention monitor against the local tri-state driver
// Rev 1.0
// ============================================================================
`default_nettype none

module std_io_in_filt
    import std_io_in_filt_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CNT    = 4,
    parameter logic RST_VAL     = 1'b0,
    parameter int   CONT_DLY    = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic ena,
    inout  wire  pad_io,
    input  logic drv_mon,
    input  logic data_mon,
    input  logic cont_clr,
    output logic level,
    output logic rise,
    output logic fall,
    output logic contention
);

    localparam int CNT_W      = $clog2(FILT_CNT + 1);
    localparam int SETTLE_MAX = SYNC_STAGES + CONT_DLY;
    localparam int SET_W      = $clog2(SETTLE_MAX + 1);

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filt_state_e;

    assign pad_io = 1'bz;

    logic pad_s;
    logic pad_sync;

    assign pad_s = pad_high(pad_io);

    std_sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk  (clk),
        .clrn (clrn),
        .d_i  (pad_s),
        .q_o  (pad_sync)
    );

    filt_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Strobes are cleared every cycle and raised only on the accepting edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (ena) begin
                case (state_q)
                    STABLE: begin
                        if (pad_sync != level_q) begin
                            if (FILT_CNT == 1) begin
                                level_q <= pad_sync;
                                rise_q  <= pad_sync;
                                fall_q  <= ~pad_sync;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q   <= CNT_W'(1);
                                state_q <= PENDING;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    PENDING: begin
                        if (pad_sync == level_q) begin
                            cnt_q   <= '0;
                            state_q <= STABLE;
                        end else if (cnt_q == CNT_W'(FILT_CNT - 1)) begin
                            level_q <= pad_sync;
                            rise_q  <= pad_sync;
                            fall_q  <= ~pad_sync;
                            cnt_q   <= '0;
                            state_q <= STABLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= STABLE;
                    end
                endcase
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic             data_prev_q;
    logic             cont_q;
    logic             cont_d;
    logic             cont_set;

    // The check fires on the cycle the settle counter reaches its ceiling,
    // giving the synchroniser plus CONT_DLY cycles to see the driven value.
    always_comb begin
        settle_d = '0;
        if (drv_mon && (data_mon == data_prev_q)) begin
            if (settle_q == SET_W'(SETTLE_MAX)) begin
                settle_d = settle_q;
            end else begin
                settle_d = settle_q + SET_W'(1);
            end
        end
        cont_set = (settle_d == SET_W'(SETTLE_MAX)) && (pad_sync != data_mon);
        cont_d   = cont_set | (cont_q & ~cont_clr);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            settle_q    <= '0;
            data_prev_q <= 1'b0;
            cont_q      <= 1'b0;
        end else begin
            settle_q    <= settle_d;
            data_prev_q <= data_mon;
            cont_q      <= cont_d;
        end
    end

    assign contention = cont_q;

endmodule

`default_nettype wire

// File: tb/tb_std_io_in_filt.sv
// ============================================================================
// tb_std_io_in_filt : scoreboard bench for std_io_in_filt
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_std_io_in_filt;

    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int CDLY  = 2;
    localparam int SMAX  = SYNC + CDLY;

    logic clk;
    logic clrn;
    logic ena;
    logic drv_mon;
    logic data_mon;
    logic cont_clr;
    logic level;
    logic rise;
    logic fall;
    logic contention;
    logic tb_oe;
    logic tb_val;
    wire  pad_io;

    assign pad_io = tb_oe ? tb_val : 1'bz;

    std_io_in_filt #(
        .SYNC_STAGES (SYNC),
        .FILT_CNT    (FILT),
        .RST_VAL     (1'b0),
        .CONT_DLY    (CDLY)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ena        (ena),
        .pad_io     (pad_io),
        .drv_mon    (drv_mon),
        .data_mon   (data_mon),
        .cont_clr   (cont_clr),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .contention (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic cont;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [SYNC-1:0] m_sh;
    logic            m_level;
    logic            m_rise;
    logic            m_fall;
    logic            m_cont;
    int              m_run;
    int              m_settle;
    logic            m_dprev;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh     = '0;
        m_level  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_cont   = 1'b0;
        m_run    = 0;
        m_settle = 0;
        m_dprev  = 1'b0;
    endtask

    // Advance model with the inputs now applied, queue its prediction,
    // then clock the DUT and compare against the popped entry.
    task automatic tick();
        logic s;
        logic p;
        exp_t e;
        exp_t got;
        if (!clrn) begin
            model_reset();
        end else begin
            s = m_sh[SYNC-1];
            p = tb_oe & tb_val;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (ena) begin
                if (s != m_level) begin
                    m_run++;
                    if (m_run == FILT) begin
                        m_level = s;
                        m_rise  = s;
                        m_fall  = ~s;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            if (drv_mon && data_mon == m_dprev)
                m_settle = (m_settle < SMAX) ? m_settle + 1 : SMAX;
            else
                m_settle = 0;
            if (m_settle == SMAX && s != data_mon) m_cont = 1'b1;
            else if (cont_clr)                     m_cont = 1'b0;
            m_dprev = data_mon;
            m_sh    = {m_sh[SYNC-2:0], p};
        end
        e.level = m_level;
        e.rise  = m_rise;
        e.fall  = m_fall;
        e.cont  = m_cont;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("sb_level", level, got.level);
        chk("sb_rise", rise, got.rise);
        chk("sb_fall", fall, got.fall);
        chk("sb_cont", contention, got.cont);
        chk("sb_rise_fall_excl", rise & fall, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clrn     = 1'b0;
        ena      = 1'b1;
        drv_mon  = 1'b0;
        data_mon = 1'b0;
        cont_clr = 1'b0;
        tb_oe    = 1'b1;
        tb_val   = 1'b1;
        model_reset();

        // Reset with pad high
        #3;
        chk("rst_level", level, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_cont", contention, 1'b0);
        ticks(3);
        clrn = 1'b1;
        ticks(5);
        chk("rst_no_early_rise", rise, 1'b0);
        tick();
        chk("rst_rise_at6", rise, 1'b1);
        chk("rst_level_at6", level, 1'b1);

        // Glitch rejection then qualified rise
        tb_val = 1'b0;
        ticks(10);
        chk("gl_low", level, 1'b0);
        tb_val = 1'b1;
        ticks(3);
        tb_val = 1'b0;
        ticks(10);
        chk("gl_rejected", level, 1'b0);
        tb_val = 1'b1;
        ticks(5);
        chk("gl_no_rise5", rise, 1'b0);
        tick();
        chk("gl_rise6", rise, 1'b1);
        tick();
        chk("gl_rise_1cyc", rise, 1'b0);
        chk("gl_level_hi", level, 1'b1);

        // ena every 4th clock
        tb_val = 1'b0;
        ticks(10);
        tb_val = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ena = (i % 4 == 3);
            tick();
            if (i == 14) chk("ena_not_early", level, 1'b0);
        end
        chk("ena_rise", rise, 1'b1);
        tb_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ena = (i % 4 == 3);
            tick();
            if (i == 14) chk("ena_fall_not_early", level, 1'b1);
        end
        chk("ena_fall", fall, 1'b1);
        ena = 1'b1;

        // Contention: driver drives 1, pad pulled to 0
        tb_val   = 1'b0;
        data_mon = 1'b1;
        ticks(6);
        drv_mon = 1'b1;
        ticks(3);
        chk("cont_not_yet", contention, 1'b0);
        tick();
        chk("cont_at4", contention, 1'b1);
        cont_clr = 1'b1;
        tick();
        chk("cont_clr_set_wins", contention, 1'b1);
        cont_clr = 1'b0;
        tb_val   = 1'b1;
        ticks(4);
        cont_clr = 1'b1;
        tick();
        chk("cont_cleared", contention, 1'b0);
        cont_clr = 1'b0;

        // No false flag while pad follows a toggling driver
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) begin
                data_mon = ~data_mon;
                tb_val   = data_mon;
            end
            tick();
        end
        chk("nf_toggle", contention, 1'b0);
        drv_mon = 1'b0;
        tb_val  = ~data_mon;
        ticks(10);
        chk("nf_drv_off", contention, 1'b0);

        // Async reset while a rise is pending
        tb_val = 1'b0;
        ticks(10);
        tb_val = 1'b1;
        ticks(4);
        #2;
        clrn = 1'b0;
        #1;
        model_reset();
        chk("ar_level", level, 1'b0);
        chk("ar_rise", rise, 1'b0);
        ticks(2);
        clrn = 1'b1;
        ticks(5);
        chk("ar_no_early_rise", rise, 1'b0);
        tick();
        chk("ar_requal_rise", rise, 1'b1);
        tb_oe = 1'b0;
        ticks(10);
        chk("ar_padz_low", level, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
